// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed 7-segment scanner with inter-digit blanking.
// Latches four BCD digits and decimal points, then scans them onto shared
// active-low segment lines and per-digit active-low anodes.
// Optional build macro LEADING_ZERO_BLANK_EN: blanks leading zero digits 3..1.
module bcd_display_scanner #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [15:0] BLANK_CYCLES = 16'd16
) (
    input  logic        clk_out,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    logic [15:0] digit_q, digit_d;
    logic [3:0]  dp_q, dp_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  idx_q, idx_d;
    logic        frame_done_q, frame_done_d;

    logic        last_slot;
    logic        blank_phase;
    logic [3:0]  nibble;
    logic        suppress;

    // Active-low CA..CG; anything outside 0..9 shows a minus sign.
    function automatic logic [6:0] decode_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    // Next-state: capture strobe, slot timer and digit index advance.
    always_comb begin
        digit_d      = load ? bcd_in : digit_q;
        dp_d         = load ? dp_in : dp_q;
        last_slot    = (timer_q == SCAN_DIV - 16'd1);
        timer_d      = last_slot ? 16'd0 : timer_q + 16'd1;
        idx_d        = last_slot ? idx_q + 2'd1 : idx_q;
        // Registered, so the pulse lands in the cycle after the 3->0 wrap edge.
        frame_done_d = last_slot && (idx_q == 2'd3);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            digit_q      <= 16'd0;
            dp_q         <= 4'd0;
            timer_q      <= 16'd0;
            idx_q        <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] is_zero;
    logic [3:0] lead_zero;

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            is_zero[i] = (digit_q[i*4 +: 4] == 4'd0);
        end
        lead_zero[3] = is_zero[3];
        lead_zero[2] = is_zero[2] & lead_zero[3];
        lead_zero[1] = is_zero[1] & lead_zero[2];
        lead_zero[0] = 1'b0;
        suppress     = lead_zero[idx_q];
    end
`else
    assign suppress = 1'b0;
`endif

    // Output decode; reset gates outputs off without waiting for a clock.
    always_comb begin
        nibble      = digit_q[idx_q*4 +: 4];
        blank_phase = (timer_q < BLANK_CYCLES);
        an          = 4'b1111;
        seg         = 7'b1111111;
        dp          = 1'b1;
        if (reset && !blank_phase) begin
            an  = ~(4'b0001 << idx_q);
            seg = suppress ? 7'b1111111 : decode_seg(nibble);
            dp  = ~dp_q[idx_q];
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner (SCAN_DIV=8, BLANK_CYCLES=2).
// Cycle k counts rising edges since reset release; timer=k%8, idx=(k/8)%4.
module tb_bcd_display_scanner;

    logic        clk_out;
    logic        reset;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int k        = 0;
    int viol     = 0;
    int fd_cnt   = 0;

    localparam logic [6:0] SegOff   = 7'b1111111;
    localparam logic [6:0] SegMinus = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SegLeadZero = 7'b1111111;
`else
    localparam logic [6:0] SegLeadZero = 7'b0000001;
`endif

    bcd_display_scanner #(
        .SCAN_DIV     (16'd8),
        .BLANK_CYCLES (16'd2)
    ) u_dut (
        .clk_out    (clk_out),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clk_out = 1'b0;
        forever #5 clk_out = ~clk_out;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    // One clock, sampled 2ns after the edge, with anode and frame monitors.
    task automatic tick();
        @(posedge clk_out);
        #2;
        k++;
        if ($countones(~an) > 1) viol++;
        if (frame_done) fd_cnt++;
    endtask

    task automatic tick_to(input int target);
        while (k < target) tick();
    endtask

    initial begin
        reset  = 1'b0;
        load   = 1'b1;
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;
        repeat (3) @(posedge clk_out);
        #2;
        check_eq("rst_an", 32'(an), 32'(4'b1111));
        check_eq("rst_seg", 32'(seg), 32'(SegOff));
        check_eq("rst_dp", 32'(dp), 32'(1'b1));
        check_eq("rst_fd", 32'(frame_done), 32'(1'b0));

        // Release; first edge captures 1234.
        reset = 1'b1;
        k = 0;
        check_eq("k0_an", 32'(an), 32'(4'b1111));
        tick_to(1);
        load = 1'b0;
        check_eq("k1_blank_an", 32'(an), 32'(4'b1111));
        check_eq("k1_blank_seg", 32'(seg), 32'(SegOff));
        tick_to(2);
        check_eq("d0_an", 32'(an), 32'(4'b1110));
        check_eq("d0_seg4", 32'(seg), 32'(7'b1001100));
        check_eq("d0_dp", 32'(dp), 32'(1'b1));
        tick_to(7);
        check_eq("d0_end_seg4", 32'(seg), 32'(7'b1001100));
        tick_to(8);
        check_eq("d1_blank_an", 32'(an), 32'(4'b1111));
        tick_to(10);
        check_eq("d1_an", 32'(an), 32'(4'b1101));
        check_eq("d1_seg3", 32'(seg), 32'(7'b0000110));
        tick_to(18);
        check_eq("d2_an", 32'(an), 32'(4'b1011));
        check_eq("d2_seg2", 32'(seg), 32'(7'b0010010));
        tick_to(26);
        check_eq("d3_an", 32'(an), 32'(4'b0111));
        check_eq("d3_seg1", 32'(seg), 32'(7'b1001111));
        tick_to(31);
        check_eq("fd_k31", 32'(frame_done), 32'(1'b0));
        tick_to(32);
        check_eq("fd_k32", 32'(frame_done), 32'(1'b1));
        check_eq("k32_an", 32'(an), 32'(4'b1111));
        tick_to(33);
        check_eq("fd_k33", 32'(frame_done), 32'(1'b0));
        tick_to(64);
        check_eq("fd_k64", 32'(frame_done), 32'(1'b1));

        // Invalid nibble with decimal point on digit1.
        tick_to(70);
        check_eq("fd_count", 32'(fd_cnt), 32'd2);
        bcd_in = 16'h00A5;
        dp_in  = 4'b0010;
        load   = 1'b1;
        tick_to(71);
        load = 1'b0;
        tick_to(74);
        check_eq("a5_d1_an", 32'(an), 32'(4'b1101));
        check_eq("a5_d1_minus", 32'(seg), 32'(SegMinus));
        check_eq("a5_d1_dp", 32'(dp), 32'(1'b0));
        tick_to(82);
        check_eq("a5_d2_zero", 32'(seg), 32'(SegLeadZero));
        check_eq("a5_d2_dp", 32'(dp), 32'(1'b1));
        tick_to(90);
        check_eq("a5_d3_zero", 32'(seg), 32'(SegLeadZero));
        check_eq("a5_d3_an", 32'(an), 32'(4'b0111));
        tick_to(98);
        check_eq("a5_d0_seg5", 32'(seg), 32'(7'b0100100));
        check_eq("a5_d0_dp", 32'(dp), 32'(1'b1));

        // 0005: digits 3..1 are leading zeros.
        tick_to(100);
        bcd_in = 16'h0005;
        dp_in  = 4'b0000;
        load   = 1'b1;
        tick_to(101);
        load = 1'b0;
        tick_to(106);
        check_eq("lz_d1_an", 32'(an), 32'(4'b1101));
        check_eq("lz_d1_seg", 32'(seg), 32'(SegLeadZero));
        tick_to(114);
        check_eq("lz_d2_seg", 32'(seg), 32'(SegLeadZero));
        tick_to(122);
        check_eq("lz_d3_seg", 32'(seg), 32'(SegLeadZero));
        tick_to(130);
        check_eq("lz_d0_seg5", 32'(seg), 32'(7'b0100100));

        // Mid-SHOW load: digit0 7 then 8.
        tick_to(132);
        bcd_in = 16'h0007;
        load   = 1'b1;
        tick_to(133);
        check_eq("ld_seg7", 32'(seg), 32'(7'b0001111));
        bcd_in = 16'h0008;
        tick_to(134);
        load = 1'b0;
        check_eq("ld_seg8", 32'(seg), 32'(7'b0000000));
        check_eq("ld_an", 32'(an), 32'(4'b1110));
        tick_to(136);
        check_eq("ld_slot_end_an", 32'(an), 32'(4'b1111));
        tick_to(138);
        check_eq("ld_d1_an", 32'(an), 32'(4'b1101));

        // Asynchronous reset in the middle of digit2's SHOW phase.
        tick_to(147);
        check_eq("pre_rst_an", 32'(an), 32'(4'b1011));
        reset = 1'b0;
        #1;
        check_eq("mid_rst_an", 32'(an), 32'(4'b1111));
        check_eq("mid_rst_seg", 32'(seg), 32'(SegOff));
        check_eq("mid_rst_dp", 32'(dp), 32'(1'b1));
        @(posedge clk_out);
        #2;
        reset = 1'b1;
        k = 0;
        check_eq("rel_an", 32'(an), 32'(4'b1111));
        check_eq("rel_fd", 32'(frame_done), 32'(1'b0));
        tick_to(2);
        check_eq("rel_d0_an", 32'(an), 32'(4'b1110));
        check_eq("rel_d0_seg0", 32'(seg), 32'(7'b0000001));
        check_eq("rel_d0_dp", 32'(dp), 32'(1'b1));

        check_eq("onehot_anodes", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Four-digit multiplexed 7-segment driver downstream of the BCD counter stage; replaces the single-digit, AN-tied-low display path.
- Latches four BCD digits plus decimal points and time-multiplexes them onto shared active-low segment lines and per-digit active-low anodes.
- Inserts a blanking interval between digits to suppress ghosting, and flags invalid codes.

Parameters:
- SCAN_DIV, 16'd50000: clk_out cycles per digit slot; legal range 2..65535.
- BLANK_CYCLES, 16'd16: cycles at the start of each slot with all anodes off; must be < SCAN_DIV; 0 disables blanking.

Ports:
- clk_out  input  1  block clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- bcd_in  input  16  digits: [3:0]=digit0 (rightmost), [7:4]=digit1, [11:8]=digit2, [15:12]=digit3.
- dp_in  input  4  decimal point request per digit; 1=lit; bit n = digit n.
- load  input  1  capture strobe for bcd_in/dp_in.
- seg  output  7  active-low segments; seg[6]=CA ... seg[0]=CG.
- dp  output  1  active-low decimal point.
- an  output  4  active-low anodes; an[n] = digit n.
- frame_done  output  1  one-cycle pulse at the end of a full 4-digit scan.

Behaviour:
- Registers: digit_reg[15:0], dp_reg[3:0], timer[15:0], idx[1:0], frame_done.
- Reset, asynchronous, any time including mid-slot:
  - digit_reg=0, dp_reg=0, timer=0, idx=0, frame_done=0.
  - Outputs forced immediately: an=4'b1111, seg=7'b1111111, dp=1.
- Capture: load=1 on a rising edge copies bcd_in→digit_reg and dp_in→dp_in reg (dp_reg). New value is visible from the next cycle, including mid-slot. load=0 holds.
- Timer and digit advance:
  - timer increments every cycle.
  - At timer==SCAN_DIV-1: timer→0 and idx→idx+1, wrapping 3→0.
- frame_done=1 for exactly the one cycle after the edge where idx wraps 3→0; 0 otherwise.
- Output decode is combinational from registers (phase derived from timer):
  - BLANK phase, timer < BLANK_CYCLES: an=4'b1111, seg=7'b1111111, dp=1.
  - SHOW phase, otherwise: an has only bit idx low; seg=decode(digit_reg nibble idx); dp=~dp_reg[idx].
- Decode, active-low CA..CG:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15 (invalid) = 1111110, a minus sign (CG only).
- Frame period = 4*SCAN_DIV cycles; each digit lit SCAN_DIV-BLANK_CYCLES cycles per frame.
- No more than one anode is ever low at a time, in any cycle including reset release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit n (n=3..1) is suppressed when its nibble is 0 and every higher nibble is 0. Digit0 is never suppressed.
  - A suppressed digit drives seg=7'b1111111 with its anode still asserted in SHOW phase; dp still follows dp_reg.
  - Invalid nibbles count as non-zero.
- Undefined: all digits always decoded; zeros shown as "0".

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2):
- Reset then load bcd_in=16'h1234, dp_in=0 → slot idx0: cycles 0-1 an=1111; cycles 2-7 an=1110, seg=1001100 ("4"). Next slot: an=1101, seg=0000110 ("3").
- Free-run 32 cycles after reset → frame_done pulses once at cycle 32 (idx wrap). Repeats every 32 cycles. No cycle has more than one an bit low.
- Load 16'h00A5, dp_in=4'b0010 → digit1 seg=1111110 (minus) with dp=0; digit0 "5", dp=1.
- With LEADING_ZERO_BLANK_EN, load 16'h0005 → digits 3,2,1 seg=1111111 in their SHOW phase; digit0 shows 0100100. Without the macro, digits 3..1 show 0000001.
- Assert reset low mid-SHOW of idx2 → an=1111, seg=1111111, dp=1 immediately. After release, scan restarts at idx0 BLANK with digit_reg=0.
- Load pulse mid-SHOW changing digit0 from 7 to 8 → seg changes 0001111→0000000 the cycle after the load edge; timer and idx unaffected.
